// File: rtl/fde_datapath_core.sv
// Fetch, decode and execute datapath of the 16-bit five-stage pipelined CPU.
// Holds the fetch PC, splits the decode-stage instruction and owns the register
// file. It also forwards the execute operands and computes the ALU result with
// NZVC flags. The ALU result doubles as the branch target for the next PC.
`timescale 1ns/1ps

module fde_datapath_core #(
   parameter int WIDTH            = 16,
   parameter int REGNUM           = 16,
   parameter int ADDRESSWIDTH     = 4,
   parameter int OPCODEWIDTH      = 4,
   parameter int INSTRUCTIONWIDTH = 24
) (
   input  logic                        clock,
   input  logic                        reset,
   // fetch
   input  logic                        fetchEnable,
   input  logic                        takeBranch,
   output logic [WIDTH-1:0]            PC,
   // decode
   input  logic [INSTRUCTIONWIDTH-1:0] instructionD,
   input  logic [WIDTH-1:0]            PCD,
   input  logic                        obtainPCAsR1,
   input  logic                        writeEnableWB,
   input  logic [ADDRESSWIDTH-1:0]     writeAddressWB,
   input  logic [WIDTH-1:0]            writeDataWB,
   output logic [WIDTH-1:0]            reg1Content,
   output logic [WIDTH-1:0]            reg2Content,
   output logic [WIDTH-1:0]            immediate,
   output logic [ADDRESSWIDTH-1:0]     regDestinationAddress,
   output logic [ADDRESSWIDTH-1:0]     reg1Address,
   output logic [ADDRESSWIDTH-1:0]     reg2Address,
   output logic [OPCODEWIDTH-1:0]      opcode,
   // execute
   input  logic [WIDTH-1:0]            reg1E,
   input  logic [WIDTH-1:0]            reg2E,
   input  logic [WIDTH-1:0]            immediateE,
   input  logic [WIDTH-1:0]            forwardM,
   input  logic [WIDTH-1:0]            forwardWB,
   input  logic [1:0]                  data1ForwardSelector,
   input  logic [1:0]                  data2ForwardSelector,
   input  logic                        data2Selector,
   input  logic [2:0]                  aluControl,
   output logic [WIDTH-1:0]            reg2Final,
   output logic [WIDTH-1:0]            aluOutput,
   output logic                        N,
   output logic                        Z,
   output logic                        V,
   output logic                        C
);

   localparam logic [2:0] ALU_ADD  = 3'b000;
   localparam logic [2:0] ALU_SUB  = 3'b001;
   localparam logic [2:0] ALU_AND  = 3'b010;
   localparam logic [2:0] ALU_OR   = 3'b011;
   localparam logic [2:0] ALU_XOR  = 3'b100;
   localparam logic [2:0] ALU_SHL  = 3'b101;
   localparam logic [2:0] ALU_SHR  = 3'b110;

   localparam logic [1:0] FWD_WB   = 2'b01;
   localparam logic [1:0] FWD_M    = 2'b10;

   logic [WIDTH-1:0] regFile [REGNUM];
   logic [WIDTH-1:0] rfRead1;
   logic [WIDTH-1:0] rfRead2;
   logic [WIDTH-1:0] operandA;
   logic [WIDTH-1:0] operandB;
   logic [WIDTH-1:0] aluResult;
   logic [WIDTH:0]   aluSum;
   logic             aluCarry;
   logic             aluOverflow;

   // The PC advances by one, or jumps to the ALU result on a taken branch.
   // When a stall drops fetchEnable, the PC holds its value.
   always_ff @(posedge clock) begin
      if (reset)
         PC <= '0;
      else if (fetchEnable)
         PC <= takeBranch ? aluOutput : PC + WIDTH'(1);
   end

   // The register file is cleared on reset. Reset wins over a write-back in
   // the same cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < REGNUM; i++)
            regFile[i] <= '0;
      end
      else if (writeEnableWB)
         regFile[writeAddressWB] <= writeDataWB;
   end

   assign opcode                = instructionD[INSTRUCTIONWIDTH-1 -: OPCODEWIDTH];
   assign regDestinationAddress = instructionD[INSTRUCTIONWIDTH-OPCODEWIDTH-1 -: ADDRESSWIDTH];
   assign reg1Address           = instructionD[INSTRUCTIONWIDTH-OPCODEWIDTH-ADDRESSWIDTH-1 -: ADDRESSWIDTH];
   assign reg2Address           = instructionD[INSTRUCTIONWIDTH-OPCODEWIDTH-2*ADDRESSWIDTH-1 -: ADDRESSWIDTH];
   assign immediate             = {{(WIDTH-8){instructionD[7]}}, instructionD[7:0]};

   // Register reads bypass the write port, so that write-back and decode can
   // share a cycle. Operand 1 can also be replaced by the decode-stage PC.
   always_comb begin
      rfRead1 = regFile[reg1Address];
      rfRead2 = regFile[reg2Address];
      if (writeEnableWB && (writeAddressWB == reg1Address))
         rfRead1 = writeDataWB;
      if (writeEnableWB && (writeAddressWB == reg2Address))
         rfRead2 = writeDataWB;
      reg1Content = obtainPCAsR1 ? PCD : rfRead1;
      reg2Content = rfRead2;
   end

   // Forwarding muxes choose between the register value and the later-stage
   // results. The unused select code falls back to the register value.
   always_comb begin
      case (data1ForwardSelector)
         FWD_WB:  operandA = forwardWB;
         FWD_M:   operandA = forwardM;
         default: operandA = reg1E;
      endcase
      case (data2ForwardSelector)
         FWD_WB:  reg2Final = forwardWB;
         FWD_M:   reg2Final = forwardM;
         default: reg2Final = reg2E;
      endcase
      operandB = data2Selector ? immediateE : reg2Final;
   end

   // The ALU sets carry and overflow only for add and subtract. Subtract uses
   // A + ~B + 1, so carry means "no borrow", i.e. A >= B unsigned.
   always_comb begin
      aluSum      = '0;
      aluResult   = '0;
      aluCarry    = 1'b0;
      aluOverflow = 1'b0;
      case (aluControl)
         ALU_ADD: begin
            aluSum      = {1'b0, operandA} + {1'b0, operandB};
            aluResult   = aluSum[WIDTH-1:0];
            aluCarry    = aluSum[WIDTH];
            aluOverflow = (operandA[WIDTH-1] == operandB[WIDTH-1]) &&
                          (aluResult[WIDTH-1] != operandA[WIDTH-1]);
         end
         ALU_SUB: begin
            aluSum      = {1'b0, operandA} + {1'b0, ~operandB} + (WIDTH+1)'(1);
            aluResult   = aluSum[WIDTH-1:0];
            aluCarry    = aluSum[WIDTH];
            aluOverflow = (operandA[WIDTH-1] != operandB[WIDTH-1]) &&
                          (aluResult[WIDTH-1] != operandA[WIDTH-1]);
         end
         ALU_AND: aluResult = operandA & operandB;
         ALU_OR:  aluResult = operandA | operandB;
         ALU_XOR: aluResult = operandA ^ operandB;
         ALU_SHL: aluResult = operandA << operandB[3:0];
         ALU_SHR: aluResult = operandA >> operandB[3:0];
         default: aluResult = operandB;
      endcase
   end

   assign aluOutput = aluResult;
   assign N         = aluResult[WIDTH-1];
   assign Z         = (aluResult == '0);
   assign V         = aluOverflow;
   assign C         = aluCarry;

endmodule

// File: tb/tb_fde_datapath_core.sv
// Directed bench for fde_datapath_core. It covers fetch PC sequencing, decode
// and the register file, execute forwarding, and the ALU results and flags.
`timescale 1ns/1ps

module tb_fde_datapath_core;

   logic        clock = 1'b0;
   logic        reset;
   logic        fetchEnable;
   logic        takeBranch;
   logic [15:0] PC;
   logic [23:0] instructionD;
   logic [15:0] PCD;
   logic        obtainPCAsR1;
   logic        writeEnableWB;
   logic [3:0]  writeAddressWB;
   logic [15:0] writeDataWB;
   logic [15:0] reg1Content;
   logic [15:0] reg2Content;
   logic [15:0] immediate;
   logic [3:0]  regDestinationAddress;
   logic [3:0]  reg1Address;
   logic [3:0]  reg2Address;
   logic [3:0]  opcode;
   logic [15:0] reg1E;
   logic [15:0] reg2E;
   logic [15:0] immediateE;
   logic [15:0] forwardM;
   logic [15:0] forwardWB;
   logic [1:0]  data1ForwardSelector;
   logic [1:0]  data2ForwardSelector;
   logic        data2Selector;
   logic [2:0]  aluControl;
   logic [15:0] reg2Final;
   logic [15:0] aluOutput;
   logic        N;
   logic        Z;
   logic        V;
   logic        C;

   int checkCount = 0;
   int passCount  = 0;

   fde_datapath_core dut (
      .clock                 (clock),
      .reset                 (reset),
      .fetchEnable           (fetchEnable),
      .takeBranch            (takeBranch),
      .PC                    (PC),
      .instructionD          (instructionD),
      .PCD                   (PCD),
      .obtainPCAsR1          (obtainPCAsR1),
      .writeEnableWB         (writeEnableWB),
      .writeAddressWB        (writeAddressWB),
      .writeDataWB           (writeDataWB),
      .reg1Content           (reg1Content),
      .reg2Content           (reg2Content),
      .immediate             (immediate),
      .regDestinationAddress (regDestinationAddress),
      .reg1Address           (reg1Address),
      .reg2Address           (reg2Address),
      .opcode                (opcode),
      .reg1E                 (reg1E),
      .reg2E                 (reg2E),
      .immediateE            (immediateE),
      .forwardM              (forwardM),
      .forwardWB             (forwardWB),
      .data1ForwardSelector  (data1ForwardSelector),
      .data2ForwardSelector  (data2ForwardSelector),
      .data2Selector         (data2Selector),
      .aluControl            (aluControl),
      .reg2Final             (reg2Final),
      .aluOutput             (aluOutput),
      .N                     (N),
      .Z                     (Z),
      .V                     (V),
      .C                     (C)
   );

   // Free-running clock with a 10 ns period.
   always #5 clock = ~clock;

   // Compare one observed value against its hand-computed expectation.
   task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
   endtask

   // Drive an ALU operation: A comes from reg1E and B from immediateE.
   task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
      data1ForwardSelector = 2'b00;
      data2ForwardSelector = 2'b00;
      data2Selector        = 1'b1;
      reg1E                = a;
      immediateE           = b;
      aluControl           = op;
      #1;
   endtask

   // Advance past the next rising edge. Sampling then happens 1 ns later.
   task automatic stepClock();
      @(posedge clock);
      #1;
   endtask

   // Directed test sequence.
   initial begin
      reset = 1'b1;  fetchEnable = 1'b0;  takeBranch = 1'b0;
      instructionD = '0;  PCD = '0;  obtainPCAsR1 = 1'b0;
      writeEnableWB = 1'b0;  writeAddressWB = '0;  writeDataWB = '0;
      reg1E = '0;  reg2E = '0;  immediateE = '0;  forwardM = '0;  forwardWB = '0;
      data1ForwardSelector = '0;  data2ForwardSelector = '0;
      data2Selector = 1'b0;  aluControl = 3'b000;

      // reset state
      stepClock();
      checkOutput("resetPC", PC, 16'h0000);
      instructionD = 24'h000500;
      #1;
      checkOutput("resetRF", reg2Content, 16'h0000);

      // increment and hold
      reset = 1'b0;  fetchEnable = 1'b1;
      stepClock();  checkOutput("pcInc1", PC, 16'h0001);
      stepClock();  checkOutput("pcInc2", PC, 16'h0002);
      stepClock();  checkOutput("pcInc3", PC, 16'h0003);
      fetchEnable = 1'b0;
      stepClock();  checkOutput("pcHold", PC, 16'h0003);
      fetchEnable = 1'b1;
      stepClock();  stepClock();
      checkOutput("pcAt5", PC, 16'h0005);

      // branch to ALU result, then reset wins over the branch
      applyStimulus(16'h0010, 16'h0004, 3'b000);
      takeBranch = 1'b1;
      #1;
      checkOutput("branchTarget", aluOutput, 16'h0014);
      stepClock();  checkOutput("pcBranch", PC, 16'h0014);
      reset = 1'b1;
      stepClock();  checkOutput("pcResetPrio", PC, 16'h0000);
      reset = 1'b0;  takeBranch = 1'b0;  fetchEnable = 1'b0;

      // register file bypass, storage and PC-as-R1
      writeEnableWB = 1'b1;  writeAddressWB = 4'd3;  writeDataWB = 16'hBEEF;
      instructionD = 24'h003000;
      #1;
      checkOutput("rfBypass", reg1Content, 16'hBEEF);
      stepClock();
      writeEnableWB = 1'b0;
      #1;
      checkOutput("rfStored", reg1Content, 16'hBEEF);
      obtainPCAsR1 = 1'b1;  PCD = 16'h0022;
      #1;
      checkOutput("pcAsR1", reg1Content, 16'h0022);
      obtainPCAsR1 = 1'b0;

      // decode field split and sign extension
      instructionD = 24'h5A3CFE;
      #1;
      checkOutput("opcode", {12'h0, opcode}, 16'h0005);
      checkOutput("destAddr", {12'h0, regDestinationAddress}, 16'h000A);
      checkOutput("r1Addr", {12'h0, reg1Address}, 16'h0003);
      checkOutput("r2Addr", {12'h0, reg2Address}, 16'h000C);
      checkOutput("immNeg", immediate, 16'hFFFE);
      checkOutput("decR1", reg1Content, 16'hBEEF);
      checkOutput("decR2", reg2Content, 16'h0000);
      writeEnableWB = 1'b1;  writeAddressWB = 4'hC;  writeDataWB = 16'h1111;
      #1;
      checkOutput("r2Bypass", reg2Content, 16'h1111);
      checkOutput("r1NoBypass", reg1Content, 16'hBEEF);
      instructionD = 24'h00007F;
      #1;
      checkOutput("immPos", immediate, 16'h007F);

      // reset beats a simultaneous write
      instructionD = 24'h003000;
      writeAddressWB = 4'd3;  writeDataWB = 16'h5555;  reset = 1'b1;
      stepClock();
      reset = 1'b0;  writeEnableWB = 1'b0;
      #1;
      checkOutput("rfResetPrio", reg1Content, 16'h0000);

      // forwarding
      applyStimulus(16'h0001, 16'h0000, 3'b000);
      reg2E = 16'h0002;  forwardM = 16'h0007;  forwardWB = 16'h0009;
      data1ForwardSelector = 2'b10;  #1;  checkOutput("fwdA_M", aluOutput, 16'h0007);
      data1ForwardSelector = 2'b01;  #1;  checkOutput("fwdA_WB", aluOutput, 16'h0009);
      data1ForwardSelector = 2'b00;  #1;  checkOutput("fwdA_reg", aluOutput, 16'h0001);
      data1ForwardSelector = 2'b11;  #1;  checkOutput("fwdA_11", aluOutput, 16'h0001);
      data2ForwardSelector = 2'b01;  #1;  checkOutput("fwdB_imm", reg2Final, 16'h0009);
      data2Selector = 1'b0;  aluControl = 3'b111;
      #1;
      checkOutput("fwdB_reg", reg2Final, 16'h0009);
      checkOutput("fwdB_alu", aluOutput, 16'h0009);
      data2ForwardSelector = 2'b10;  #1;  checkOutput("fwdB_M", reg2Final, 16'h0007);
      data2ForwardSelector = 2'b11;  #1;  checkOutput("fwdB_11", reg2Final, 16'h0002);

      // arithmetic and flags, packed as {N,Z,V,C}
      applyStimulus(16'h7FFF, 16'h0001, 3'b000);
      checkOutput("addOvf", aluOutput, 16'h8000);
      checkOutput("addOvfFlags", {12'h0, N, Z, V, C}, 16'b1010);
      applyStimulus(16'h0005, 16'h0005, 3'b001);
      checkOutput("subEq", aluOutput, 16'h0000);
      checkOutput("subEqFlags", {12'h0, N, Z, V, C}, 16'b0101);
      applyStimulus(16'hFFFF, 16'h0001, 3'b000);
      checkOutput("addWrap", aluOutput, 16'h0000);
      checkOutput("addWrapFlags", {12'h0, N, Z, V, C}, 16'b0101);
      applyStimulus(16'h0003, 16'h0005, 3'b001);
      checkOutput("subBorrow", aluOutput, 16'hFFFE);
      checkOutput("subBorrowFlags", {12'h0, N, Z, V, C}, 16'b1000);
      applyStimulus(16'h8000, 16'h0001, 3'b001);
      checkOutput("subOvf", aluOutput, 16'h7FFF);
      checkOutput("subOvfFlags", {12'h0, N, Z, V, C}, 16'b0011);

      // logic, shifts and pass-through
      applyStimulus(16'h00F0, 16'h0F0F, 3'b010);
      checkOutput("and", aluOutput, 16'h0000);
      checkOutput("andFlags", {12'h0, N, Z, V, C}, 16'b0100);
      applyStimulus(16'h00F0, 16'h0F0F, 3'b011);
      checkOutput("or", aluOutput, 16'h0FFF);
      applyStimulus(16'hFF00, 16'h0FF0, 3'b100);
      checkOutput("xor", aluOutput, 16'hF0F0);
      checkOutput("xorFlags", {12'h0, N, Z, V, C}, 16'b1000);
      applyStimulus(16'h0001, 16'h0004, 3'b101);
      checkOutput("shl", aluOutput, 16'h0010);
      applyStimulus(16'h0001, 16'h0014, 3'b101);
      checkOutput("shlMasked", aluOutput, 16'h0010);
      applyStimulus(16'h8000, 16'h000F, 3'b110);
      checkOutput("shr", aluOutput, 16'h0001);
      applyStimulus(16'hFFFF, 16'h1234, 3'b111);
      checkOutput("pass", aluOutput, 16'h1234);
      checkOutput("passFlags", {12'h0, N, Z, V, C}, 16'b0000);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
